// File: rtl/y_out_clamp_fifo_if.sv
// rtl/y_out_clamp_fifo_if.sv - handshake bundle between the clamp FIFO and its neighbours
// Purpose: groups the sample input, pixel output and status signals of y_out_clamp_fifo.
// Ports (slave = FIFO side):
//   i_valid, i_y[9:0]       upstream signed filter sample
//   i_ready                 downstream accepts o_data
//   i_clr_ovf               synchronous clear of the sticky overflow flag
//   o_in_ready, o_valid     not-full / not-empty
//   o_data[7:0], o_eol      clamped head pixel and end-of-line marker
//   o_count[CW-1:0], o_ovf  occupancy and sticky overflow
interface y_out_clamp_fifo_if #(
  parameter int CW = 4
);
  logic          i_valid;
  logic [9:0]    i_y;
  logic          i_ready;
  logic          i_clr_ovf;
  logic          o_in_ready;
  logic          o_valid;
  logic [7:0]    o_data;
  logic          o_eol;
  logic [CW-1:0] o_count;
  logic          o_ovf;

  modport slave (
    input  i_valid, i_y, i_ready, i_clr_ovf,
    output o_in_ready, o_valid, o_data, o_eol, o_count, o_ovf
  );

  modport master (
    output i_valid, i_y, i_ready, i_clr_ovf,
    input  o_in_ready, o_valid, o_data, o_eol, o_count, o_ovf
  );
endinterface

// File: rtl/y_out_clamp_fifo.sv
// rtl/y_out_clamp_fifo.sv - first-word-fall-through FIFO clamping signed samples to 8-bit pixels
// Purpose: clamps 10-bit signed samples to 0..255 on write, buffers DEPTH entries,
//   tags the last pixel of each LINE_WIDTH line and flags dropped samples.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  y_out_clamp_fifo_if.slave (see interface file for signal list)
module y_out_clamp_fifo #(
  parameter int DEPTH      = 8,
  parameter int LINE_WIDTH = 16,
  parameter int CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  y_out_clamp_fifo_if.slave     bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int COLW = $clog2(LINE_WIDTH);
  localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);
  localparam logic [COLW-1:0] COL_LAST   = COLW'(LINE_WIDTH - 1);

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [COLW-1:0] col;
  logic            ovf;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            ovf_set;
  logic [7:0]      clamped;

  // Status comes only from registered count, so no ready/valid input reaches these outputs.
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign push    = bus.i_valid && !full;
  assign pop     = !empty && bus.i_ready;
  // A pop in the same cycle does not free a slot for the incoming sample.
  assign ovf_set = bus.i_valid && full;

  // Sign bit set -> negative -> 0; bit 8 set on a positive value -> above 255.
  always_comb begin
    clamped = bus.i_y[7:0];
    if (bus.i_y[9])
      clamped = 8'h00;
    else if (bus.i_y[8])
      clamped = 8'hFF;
  end

  // Storage is not reset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= clamped;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      col    <= '0;
      ovf    <= 1'b0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        col    <= (col == COL_LAST) ? '0 : col + COLW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A fresh overflow takes priority over a clear in the same cycle.
      if (ovf_set)
        ovf <= 1'b1;
      else if (bus.i_clr_ovf)
        ovf <= 1'b0;
    end
  end

  assign bus.o_in_ready = !full;
  assign bus.o_valid    = !empty;
  assign bus.o_data     = mem[rd_ptr];
  assign bus.o_eol      = !empty && (col == COL_LAST);
  assign bus.o_count    = count;
  assign bus.o_ovf      = ovf;
endmodule

// File: tb/tb_y_out_clamp_fifo.sv
// tb/tb_y_out_clamp_fifo.sv - self-checking bench for y_out_clamp_fifo
module tb_y_out_clamp_fifo;
  localparam int DEPTH = 8;
  localparam int LW    = 16;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  y_out_clamp_fifo_if #(.CW(CW)) bus();

  y_out_clamp_fifo #(.DEPTH(DEPTH), .LINE_WIDTH(LW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue of pixels, a line position and a sticky flag.
  byte unsigned q[$];
  int           col = 0;
  bit           ovf = 1'b0;

  typedef struct {
    logic       v;
    logic [9:0] y;
    logic       r;
    logic       c;
    logic       ev;
    logic [7:0] ed;
    int         ec;
    logic       eir;
    logic       eovf;
  } vec_t;

  vec_t tbl[11];

  function automatic int clamp(logic [9:0] y);
    int v;
    v = $signed(y);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [9:0] y, input logic r, input logic c);
    bus.i_valid   = v;
    bus.i_y       = y;
    bus.i_ready   = r;
    bus.i_clr_ovf = c;
  endtask

  task automatic model_edge();
    bit full;
    bit do_pop;
    bit do_push;
    full    = (q.size() == DEPTH);
    do_pop  = (q.size() != 0) && bus.i_ready;
    do_push = bus.i_valid && !full;
    if (do_pop) begin
      void'(q.pop_front());
      col = (col + 1) % LW;
    end
    if (do_push) q.push_back(8'(clamp(bus.i_y)));
    if (bus.i_valid && full) ovf = 1'b1;
    else if (bus.i_clr_ovf) ovf = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_count"},    32'(bus.o_count),    q.size());
    chk({tag, "_valid"},    32'(bus.o_valid),    32'(q.size() != 0));
    chk({tag, "_in_ready"}, 32'(bus.o_in_ready), 32'(q.size() != DEPTH));
    chk({tag, "_ovf"},      32'(bus.o_ovf),      32'(ovf));
    chk({tag, "_eol"},      32'(bus.o_eol),      32'(q.size() != 0 && col == LW - 1));
    if (q.size() != 0) chk({tag, "_data"}, 32'(bus.o_data), 32'(q[0]));
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  // Called #1 after an edge; the first check happens before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    set_in(1'b0, 10'd0, 1'b0, 1'b0);
    q.delete();
    col = 0;
    ovf = 1'b0;
    #1;
    check_model("rst_async");
    @(posedge clk);
    #1;
    check_model("rst_held");
    rst = 1'b0;
  endtask

  initial begin
    set_in(1'b0, 10'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    do_reset();

    // Clamp and basic FWFT behaviour against hand-computed expectations.
    tbl[0]  = '{1'b1, 10'h3FB, 1'b1, 1'b0, 1'b1, 8'd0,   1, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 10'h12C, 1'b1, 1'b0, 1'b1, 8'd255, 1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 10'h0FF, 1'b1, 1'b0, 1'b1, 8'd255, 1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 10'h000, 1'b1, 1'b0, 1'b1, 8'd0,   1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 10'h080, 1'b1, 1'b0, 1'b1, 8'd128, 1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 8'd0,   0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 10'h200, 1'b0, 1'b0, 1'b1, 8'd0,   1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 10'h1FF, 1'b0, 1'b0, 1'b1, 8'd0,   2, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 8'd255, 1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 8'd255, 1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 8'd0,   0, 1'b1, 1'b0};
    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].v, tbl[i].y, tbl[i].r, tbl[i].c);
      cycle("tbl");
      chk($sformatf("tbl%0d_valid", i),    32'(bus.o_valid),    32'(tbl[i].ev));
      chk($sformatf("tbl%0d_count", i),    32'(bus.o_count),    tbl[i].ec);
      chk($sformatf("tbl%0d_in_ready", i), 32'(bus.o_in_ready), 32'(tbl[i].eir));
      chk($sformatf("tbl%0d_ovf", i),      32'(bus.o_ovf),      32'(tbl[i].eovf));
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), 32'(bus.o_data), 32'(tbl[i].ed));
    end

    // Fill past capacity, then drain: the ninth sample must be dropped.
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      set_in(1'b1, 10'(i), 1'b0, 1'b0);
      cycle("fill");
    end
    chk("fill_count", 32'(bus.o_count), 8);
    chk("fill_in_ready", 32'(bus.o_in_ready), 0);
    chk("fill_ovf", 32'(bus.o_ovf), 1);
    for (int i = 1; i <= 8; i++) begin
      set_in(1'b0, 10'd0, 1'b1, 1'b0);
      chk("drain_data", 32'(bus.o_data), i);
      cycle("drain");
    end
    chk("drain_empty", 32'(bus.o_valid), 0);

    // Clear racing a new overflow, then a clean clear.
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 10'(40 + i), 1'b0, 1'b0);
      cycle("refill");
    end
    set_in(1'b1, 10'd5, 1'b1, 1'b1);
    cycle("race");
    chk("race_ovf_held", 32'(bus.o_ovf), 1);
    set_in(1'b0, 10'd0, 1'b0, 1'b1);
    cycle("clr");
    chk("clr_ovf", 32'(bus.o_ovf), 0);

    // Steady push+pop at count 3 across pointer wrap.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 10'(20 + i), 1'b0, 1'b0);
      cycle("pre3");
    end
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 10'(30 + i), 1'b1, 1'b0);
      cycle("simul");
      chk("simul_count", 32'(bus.o_count), 3);
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 10'd0, 1'b1, 1'b0);
      chk("simul_tail", 32'(bus.o_data), 37 + i);
      cycle("simul_drain");
    end

    // Line marking with random stalls.
    begin : line_test
      int   popped;
      int   sent;
      int   hits[$];
      logic v;
      logic r;
      popped = 0;
      sent   = 0;
      do_reset();
      for (int n = 0; n < 1000 && popped < 40; n++) begin
        v = (sent < 40) && ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 2) != 0);
        set_in(v, 10'($urandom), r, 1'b0);
        if (v && q.size() < DEPTH) sent++;
        if (bus.o_valid && r) begin
          popped++;
          if (bus.o_eol) hits.push_back(popped);
        end
        cycle("line");
      end
      chk("line_popped", popped, 40);
      chk("line_eol_hits", hits.size(), 2);
      if (hits.size() >= 2) begin
        chk("line_eol_first", hits[0], 16);
        chk("line_eol_second", hits[1], 32);
      end
    end

    // Asynchronous reset in the middle of a stream at count 5, col 7.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_in(1'b1, 10'(i), 1'b0, 1'b0);
      cycle("mid_fill");
    end
    for (int i = 0; i < 7; i++) begin
      set_in(1'b0, 10'd0, 1'b1, 1'b0);
      cycle("mid_pop");
    end
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 10'(100 + i), 1'b0, 1'b0);
      cycle("mid_refill");
    end
    chk("mid_pre_count", 32'(bus.o_count), 5);
    do_reset();
    chk("mid_rst_valid", 32'(bus.o_valid), 0);
    set_in(1'b1, 10'd77, 1'b0, 1'b0);
    cycle("post_rst");
    chk("post_rst_data", 32'(bus.o_data), 77);
    chk("post_rst_eol", 32'(bus.o_eol), 0);
    set_in(1'b0, 10'd0, 1'b1, 1'b0);
    cycle("post_rst_pop");

    // Randomized stress against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      set_in($urandom_range(0, 2) != 0, 10'($urandom), $urandom_range(0, 1) != 0,
             $urandom_range(0, 7) == 0);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
